// File: rtl/fifo_rr_sched.sv
// Round-robin drain scheduler: shares one valid/ready consumer between NCH
// registered-read FIFOs, reading up to BURST words per grant and tagging
// each forwarded word with its source channel id.
module fifo_rr_sched #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BURST = 2,
    localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 i_clk,
    input  logic                 srst,
    input  logic [NCH-1:0]       fifo_empty,
    output logic [NCH-1:0]       fifo_rd_en,
    input  logic [NCH*WIDTH-1:0] fifo_rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CW-1:0]        out_chan,
    output logic                 out_last,
    output logic                 busy
);

    localparam int unsigned BCW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    rr_ptr;
    logic [CW-1:0]    rr_ptr_nxt;
    logic [CW-1:0]    grant;
    logic [CW-1:0]    grant_nxt;
    logic [BCW-1:0]   beat_cnt;
    logic [BCW-1:0]   beat_cnt_nxt;
    logic [WIDTH-1:0] out_data_nxt;
    logic [CW-1:0]    out_chan_nxt;
    logic             out_last_nxt;
    logic [NCH-1:0]   fifo_rd_en_nxt;

    logic             arb_found;
    logic [CW-1:0]    arb_idx;
    logic [WIDTH-1:0] rd_word;

    // Round-robin search starting at rr_ptr; the nearest non-empty channel wins.
    always_comb begin
        logic [CW-1:0] cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = int'(NCH) - 1; k >= 0; k--) begin
            cand = CW'((int'(rr_ptr) + k) % int'(NCH));
            if (!fifo_empty[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Word returned by the granted FIFO.
    always_comb begin
        rd_word = fifo_rd_data[int'(grant)*int'(WIDTH) +: WIDTH];
    end

    // Next-state and datapath decode; Moore outputs derived from the next state.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        grant_nxt    = grant;
        beat_cnt_nxt = beat_cnt;
        out_data_nxt = out_data;
        out_chan_nxt = out_chan;
        out_last_nxt = out_last;

        case (state)
            IDLE: begin
                if (arb_found) begin
                    grant_nxt    = arb_idx;
                    beat_cnt_nxt = '0;
                    state_nxt    = RD;
                end
            end
            RD: begin
                state_nxt = CAP;
            end
            CAP: begin
                // fifo_empty already reflects the read issued in RD.
                out_data_nxt = rd_word;
                out_chan_nxt = grant;
                out_last_nxt = (beat_cnt == BCW'(BURST - 1)) || fifo_empty[grant];
                state_nxt    = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (!out_last) begin
                        beat_cnt_nxt = BCW'(beat_cnt + 1'b1);
                        state_nxt    = RD;
                    end else begin
                        rr_ptr_nxt = (grant == CW'(NCH - 1)) ? '0 : CW'(grant + 1'b1);
                        state_nxt  = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        fifo_rd_en_nxt = '0;
        if (state_nxt == RD) begin
            fifo_rd_en_nxt = NCH'(1) << grant_nxt;
        end
    end

    // State, datapath and registered Moore outputs.
    always_ff @(posedge i_clk) begin
        if (srst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            beat_cnt   <= '0;
            out_data   <= '0;
            out_chan   <= '0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
            fifo_rd_en <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            grant      <= grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
            out_data   <= out_data_nxt;
            out_chan   <= out_chan_nxt;
            out_last   <= out_last_nxt;
            out_valid  <= (state_nxt == SEND);
            fifo_rd_en <= fifo_rd_en_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Bench for fifo_rr_sched: behavioural registered-read FIFOs feed the DUT,
// and a transaction-level round-robin model predicts the output beat stream.
module tb_fifo_rr_sched;

    localparam int unsigned NCH   = 4;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned BURST = 2;
    localparam int unsigned CW    = 2;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [CW-1:0]    chan;
        logic             last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 srst = 1'b1;
    logic [NCH-1:0]       fifo_empty = '1;
    logic [NCH-1:0]       fifo_rd_en;
    logic [NCH*WIDTH-1:0] fifo_rd_data;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [WIDTH-1:0]     out_data;
    logic [CW-1:0]        out_chan;
    logic                 out_last;
    logic                 busy;

    // FIFO storage seen by the DUT, and the model's copy of the same contents
    logic [WIDTH-1:0] q  [NCH][$];
    logic [WIDTH-1:0] mq [NCH][$];
    logic [WIDTH-1:0] rd_reg [NCH];
    exp_t             expq [$];
    int               mptr = 0;

    logic             push_en = 1'b0;
    int               push_ch = 0;
    logic [WIDTH-1:0] push_data = '0;
    logic             hide = 1'b1;
    int               bad_rd = 0;

    int checks = 0;
    int failures = 0;

    fifo_rr_sched #(.NCH(NCH), .WIDTH(WIDTH), .BURST(BURST)) dut (
        .i_clk       (clk),
        .srst        (srst),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_chan    (out_chan),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            fifo_rd_data[i*WIDTH +: WIDTH] = rd_reg[i];
        end
    end

    // Registered-read FIFOs; hide presents all channels as empty during a batch load
    always @(posedge clk) begin
        if (fifo_rd_en != '0 && !$onehot(fifo_rd_en)) bad_rd = bad_rd + 1;
        for (int i = 0; i < int'(NCH); i++) begin
            if (fifo_rd_en[i]) begin
                if (q[i].size() == 0) bad_rd = bad_rd + 1;
                else rd_reg[i] <= q[i].pop_front();
            end
        end
        if (push_en) q[push_ch].push_back(push_data);
        for (int i = 0; i < int'(NCH); i++) begin
            fifo_empty[i] <= hide || (q[i].size() == 0);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int ch, input logic [WIDTH-1:0] d);
        @(negedge clk);
        push_en   = 1'b1;
        push_ch   = ch;
        push_data = d;
        mq[ch].push_back(d);
        @(posedge clk);
        #1 push_en = 1'b0;
    endtask

    // Spec-level prediction: grant in rr order, up to BURST words, stop early on empty
    function automatic void build_exp();
        exp_t e;
        int   g;
        while (1) begin
            g = -1;
            for (int k = 0; k < int'(NCH); k++) begin
                if (g < 0 && mq[(mptr + k) % int'(NCH)].size() > 0) g = (mptr + k) % int'(NCH);
            end
            if (g < 0) return;
            for (int b = 0; b < int'(BURST); b++) begin
                e.data = mq[g].pop_front();
                e.chan = CW'(g);
                e.last = (b == int'(BURST) - 1) || (mq[g].size() == 0);
                expq.push_back(e);
                if (e.last) break;
            end
            mptr = (g + 1) % int'(NCH);
        end
    endfunction

    task automatic drain(input int ready_pct, input string tag);
        exp_t e;
        int   cyc;
        int   last_hs;
        logic prev_last;
        cyc = 0;
        last_hs = 0;
        prev_last = 1'b1;
        while (expq.size() > 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(99) < 32'(ready_pct));
            if (out_valid && out_ready) begin
                e = expq.pop_front();
                check({tag, "_data"}, 64'(out_data), 64'(e.data));
                check({tag, "_chan"}, 64'(out_chan), 64'(e.chan));
                check({tag, "_last"}, 64'(out_last), 64'(e.last));
                if (ready_pct == 100 && !prev_last) check({tag, "_gap"}, 64'(cyc - last_hs), 64'd3);
                prev_last = out_last;
                last_hs = cyc;
            end
        end
        check({tag, "_remaining"}, 64'(expq.size()), 64'd0);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic set_hide(input logic v);
        @(negedge clk);
        hide = v;
    endtask

    initial begin
        int n;
        logic [WIDTH+CW:0] snap;

        // 1: reset with every channel non-empty
        repeat (2) @(posedge clk);
        for (int c = 0; c < int'(NCH); c++) push(c, $urandom);
        set_hide(1'b0);
        repeat (3) begin
            @(posedge clk);
            #1 check("t1_reset_outs", 64'({fifo_rd_en, out_valid, busy}), 64'd0);
        end
        @(negedge clk);
        srst = 1'b0;
        mptr = 0;
        build_exp();
        drain(100, "t1");

        // 2: three words on ch2 only, latency and burst split
        set_hide(1'b1);
        for (int i = 0; i < 3; i++) push(2, $urandom);
        build_exp();
        set_hide(1'b0);
        @(posedge clk);
        n = 0;
        while (n < 8) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid) break;
        end
        check("t2_latency", 64'(n), 64'd3);
        drain(100, "t2");

        // 3: all channels loaded with four words
        set_hide(1'b1);
        for (int c = 0; c < int'(NCH); c++)
            for (int i = 0; i < 4; i++) push(c, $urandom);
        build_exp();
        set_hide(1'b0);
        drain(100, "t3");

        // 4: single word on ch1
        set_hide(1'b1);
        push(1, $urandom);
        build_exp();
        set_hide(1'b0);
        drain(100, "t4");

        // random loads with random backpressure
        for (int r = 0; r < 4; r++) begin
            set_hide(1'b1);
            for (int c = 0; c < int'(NCH); c++) begin
                n = int'($urandom_range(5));
                for (int i = 0; i < n; i++) push(c, $urandom);
            end
            build_exp();
            set_hide(1'b0);
            drain(60, "rnd");
        end

        // 5: long stall in SEND
        set_hide(1'b1);
        push(0, $urandom);
        push(0, $urandom);
        build_exp();
        set_hide(1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_valid", 64'(out_valid), 64'd1);
        snap = {out_data, out_chan, out_last};
        repeat (10) begin
            @(negedge clk);
            check("t5_hold", 64'({out_data, out_chan, out_last}), 64'(snap));
            check("t5_no_rd", 64'({fifo_rd_en, out_valid}), 64'h1);
        end
        drain(100, "t5");

        // 6: reset while ch3 is in CAP
        set_hide(1'b1);
        push(3, $urandom);
        set_hide(1'b0);
        n = 0;
        while (n < 10) begin
            @(posedge clk);
            n++;
            #1;
            if (fifo_rd_en[3]) break;
        end
        check("t6_rd_seen", 64'(fifo_rd_en), 64'h8);
        @(posedge clk);
        @(negedge clk);
        srst = 1'b1;
        @(posedge clk);
        #1 check("t6_abort", 64'({fifo_rd_en, out_valid, busy}), 64'd0);
        void'(mq[3].pop_front());
        mptr = 0;
        hide = 1'b1;
        push(3, $urandom);
        push(0, $urandom);
        @(negedge clk);
        srst = 1'b0;
        build_exp();
        set_hide(1'b0);
        drain(100, "t6");

        check("rd_en_legal", 64'(bad_rd), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
